// File: rtl/image_binarize_stream.sv
// Streaming frame reader that fetches pixel rows from memory and emits
// RGB, binary, inverted-binary or grayscale pixels with VSYNC/HSYNC timing.
module image_binarize_stream #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int PPC            = 2,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160,
    parameter int BOTTOM_UP      = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [7:0]           threshold,
    output logic                 mem_rd_en,
    output logic [18:0]          mem_addr,
    input  logic [PPC*24-1:0]    mem_rdata,
    output logic                 VSYNC,
    output logic                 HSYNC,
    output logic [PPC*24-1:0]    DATA,
    output logic                 ctrl_done,
    output logic                 busy
);

    localparam int BEATS = WIDTH / PPC;
    localparam int CM0   = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int CM1   = (CM0 > BEATS) ? CM0 : BEATS;
    localparam int CMAX  = (CM1 > 2) ? CM1 : 2;
    localparam int CW    = $clog2(CMAX);
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_HSYNC,
        ST_DATA,
        ST_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  row_q, row_d;
    logic [RW-1:0]  frow;
    logic           accept;
    logic [1:0]     mode_q;
    logic [7:0]     thr_q;
    logic           v1_q;

    function automatic logic [23:0] pix(
        input logic [23:0] p,
        input logic [1:0]  m,
        input logic [7:0]  thr
    );
        logic [9:0] sum;
        logic [7:0] g;
        logic       hi;
        sum = 10'(p[23:16]) + {1'b0, p[15:8], 1'b0} + 10'(p[7:0]);
        g   = 8'(sum >> 2);
        hi  = (g > thr);
        case (m)
            2'b00:   pix = p;
            2'b01:   pix = {24{hi}};
            2'b10:   pix = {24{~hi}};
            default: pix = {g, g, g};
        endcase
    endfunction

    // Next-state, counter and row sequencing for the frame walk
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !ctrl_done) begin
                    state_d = ST_VSYNC;
                    cnt_d   = '0;
                    row_d   = '0;
                    accept  = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (cnt_q == CW'(START_UP_DELAY - 1)) begin
                    state_d = ST_HSYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HSYNC: begin
                if (cnt_q == CW'(HSYNC_DELAY - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(BEATS - 1)) begin
                    cnt_d = '0;
                    if (row_q == RW'(HEIGHT - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_HSYNC;
                        row_d   = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // State, counters and the per-frame mode/threshold snapshot
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            mode_q  <= '0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            if (accept) begin
                mode_q <= mode;
                thr_q  <= threshold;
            end
        end
    end

    assign frow      = (BOTTOM_UP != 0) ? (RW'(HEIGHT - 1) - row_q) : row_q;
    assign mem_rd_en = (state_q == ST_DATA);
    assign mem_addr  = mem_rd_en ? (19'(frow) * 19'(BEATS) + 19'(cnt_q)) : '0;
    assign VSYNC     = (state_q == ST_VSYNC);
    assign busy      = (state_q != ST_IDLE) || ctrl_done;

    // Two-stage pixel pipeline: read-valid tracking, then processed output
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            v1_q  <= 1'b0;
            HSYNC <= 1'b0;
            DATA  <= '0;
        end else begin
            v1_q  <= mem_rd_en;
            HSYNC <= v1_q;
            for (int k = 0; k < PPC; k++) begin
                DATA[24*k +: 24] <= v1_q ? pix(mem_rdata[24*k +: 24], mode_q, thr_q) : 24'h0;
            end
        end
    end

    // End-of-frame pulse lands right after the last output beat
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_done <= 1'b0;
        end else begin
            ctrl_done <= (state_q == ST_DRAIN) && (cnt_q == CW'(1));
        end
    end

endmodule

// File: tb/tb_image_binarize_stream.sv
// Directed bench for image_binarize_stream: two instances (top-down and
// bottom-up) on a tiny 8x2 frame with hand-computed pixel results.
module tb_image_binarize_stream;

    logic        clk;
    logic        rst_n = 1'b1;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  threshold;

    logic        rd_en0, rd_en1;
    logic [18:0] addr0, addr1;
    logic [47:0] rdata0, rdata1;
    logic        vs0, vs1, hs0, hs1, done0, done1, busy0, busy1;
    logic [47:0] data0, data1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // pixel memory: pixel0 in low 24 bits, each {R,G,B}
    logic [47:0] mem [8] = '{
        {24'h656565, 24'h646464},
        {24'h000000, 24'hFF00FF},
        {24'h0A141E, 24'hFFFFFF},
        {24'hC86432, 24'h010203},
        {24'h686464, 24'h636564},
        {24'h000102, 24'h030000},
        {24'h402010, 24'h808080},
        {24'h00FFFF, 24'hFFFF00}
    };
    int gray0 [8] = '{100, 127, 255, 2, 100, 0, 128, 191};
    int gray1 [8] = '{101, 0, 20, 112, 101, 1, 36, 191};
    bit bin0  [8] = '{0, 1, 1, 0, 0, 0, 1, 1};
    bit bin1  [8] = '{1, 0, 0, 1, 1, 0, 0, 1};

    logic [18:0] rd_a0[$], rd_a1[$];
    int          rd_c0[$];
    logic [47:0] hs_d0[$], hs_d1[$];
    int          hs_c0[$];
    int          vs_cnt0, done_cnt0, done_cnt1, done_cyc0, zero_viol, busy_viol;

    image_binarize_stream #(
        .WIDTH(8), .HEIGHT(2), .PPC(2), .START_UP_DELAY(3),
        .HSYNC_DELAY(2), .BOTTOM_UP(0)
    ) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .start(start), .mode(mode),
        .threshold(threshold), .mem_rd_en(rd_en0), .mem_addr(addr0),
        .mem_rdata(rdata0), .VSYNC(vs0), .HSYNC(hs0), .DATA(data0),
        .ctrl_done(done0), .busy(busy0)
    );

    image_binarize_stream #(
        .WIDTH(8), .HEIGHT(2), .PPC(2), .START_UP_DELAY(3),
        .HSYNC_DELAY(2), .BOTTOM_UP(1)
    ) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .start(start), .mode(mode),
        .threshold(threshold), .mem_rd_en(rd_en1), .mem_addr(addr1),
        .mem_rdata(rdata1), .VSYNC(vs1), .HSYNC(hs1), .DATA(data1),
        .ctrl_done(done1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory with one-cycle read latency
    always @(posedge clk) begin
        rdata0 <= rd_en0 ? mem[addr0[2:0]] : 48'h0;
        rdata1 <= rd_en1 ? mem[addr1[2:0]] : 48'h0;
    end

    // monitor: log reads, output beats and pulses at the falling edge
    always @(negedge clk) begin
        if (rd_en0) begin rd_a0.push_back(addr0); rd_c0.push_back(cyc); end
        if (rd_en1) rd_a1.push_back(addr1);
        if (hs0) begin hs_d0.push_back(data0); hs_c0.push_back(cyc); end
        if (hs1) hs_d1.push_back(data1);
        if (vs0) vs_cnt0++;
        if (done0) begin done_cnt0++; done_cyc0 = cyc; end
        if (done1) done_cnt1++;
        if ((!hs0 && data0 != 48'h0) || (!hs1 && data1 != 48'h0)) zero_viol++;
        if (done0 && !busy0) busy_viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_a0.delete(); rd_a1.delete(); rd_c0.delete();
        hs_d0.delete(); hs_d1.delete(); hs_c0.delete();
        vs_cnt0 = 0; done_cnt0 = 0; done_cnt1 = 0; done_cyc0 = -1;
        zero_viol = 0; busy_viol = 0;
    endtask

    function automatic logic [47:0] exp_beat(input logic [1:0] m, input int a);
        logic [47:0] r;
        logic [7:0]  g;
        bit          b;
        r = mem[a];
        for (int k = 0; k < 2; k++) begin
            g = 8'((k == 0) ? gray0[a] : gray1[a]);
            b = (k == 0) ? bin0[a] : bin1[a];
            case (m)
                2'b01:   r[24*k +: 24] = b ? 24'hFFFFFF : 24'h000000;
                2'b10:   r[24*k +: 24] = b ? 24'h000000 : 24'hFFFFFF;
                2'b11:   r[24*k +: 24] = {g, g, g};
                default: ;
            endcase
        end
        return r;
    endfunction

    // starts a frame and returns on the falling edge where ctrl_done shows
    task automatic run_frame(input logic [1:0] m, input logic [7:0] t,
                             input bit disturb, input bit start_at_done);
        int i;
        clear_logs();
        mode = m; threshold = t; start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 64'(busy0), 64'd1);
        if (disturb) begin
            repeat (6) step();
            mode = ~m; threshold = ~t; start = 1'b1;
            step();
            start = 1'b0;
        end
        i = 0;
        while (!done0 && i < 200) begin
            step();
            i++;
        end
        check("done_seen", 64'(done0), 64'd1);
        if (start_at_done) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check("start_on_done_ignored", 64'(busy0), 64'd0);
        end
    endtask

    task automatic check_frame(input logic [1:0] m);
        check("vsync_cycles", 64'(vs_cnt0), 64'd3);
        check("rd_count0", 64'(rd_a0.size()), 64'd8);
        check("rd_count1", 64'(rd_a1.size()), 64'd8);
        check("hs_count0", 64'(hs_d0.size()), 64'd8);
        check("hs_count1", 64'(hs_d1.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_a0.size() && i < hs_d0.size()) begin
                check($sformatf("addr0[%0d]", i), 64'(rd_a0[i]), 64'(i));
                check($sformatf("data0[%0d]", i), 64'(hs_d0[i]), 64'(exp_beat(m, i)));
                check($sformatf("lat[%0d]", i), 64'(hs_c0[i] - rd_c0[i]), 64'd2);
            end
            if (i < rd_a1.size() && i < hs_d1.size()) begin
                check($sformatf("addr1[%0d]", i), 64'(rd_a1[i]), 64'((i + 4) % 8));
                check($sformatf("data1[%0d]", i), 64'(hs_d1[i]), 64'(exp_beat(m, (i + 4) % 8)));
            end
            if (i > 0 && i < hs_c0.size()) begin
                check($sformatf("gap[%0d]", i), 64'(hs_c0[i] - hs_c0[i-1]),
                      (i == 4) ? 64'd3 : 64'd1);
            end
        end
        check("done_count0", 64'(done_cnt0), 64'd1);
        check("done_count1", 64'(done_cnt1), 64'd1);
        if (hs_c0.size() == 8) check("done_after_last", 64'(done_cyc0), 64'(hs_c0[7] + 1));
        check("data_zero_idle", 64'(zero_viol), 64'd0);
        check("busy_at_done", 64'(busy_viol), 64'd0);
    endtask

    initial begin
        int i;
        start = 1'b0; mode = 2'b00; threshold = 8'd0;
        clear_logs();
        #1 rst_n = 1'b0;
        #1;
        check("rst_vsync", 64'(vs0), 64'd0);
        check("rst_hsync", 64'(hs0), 64'd0);
        check("rst_data", 64'(data0), 64'd0);
        check("rst_rd_en", 64'(rd_en0), 64'd0);
        check("rst_addr1", 64'(addr1), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("no_self_start_busy", 64'(busy0), 64'd0);
        check("no_self_start_rd", 64'(rd_a0.size()), 64'd0);

        // RGB bypass frame
        run_frame(2'b00, 8'd100, 1'b0, 1'b0);
        repeat (2) step();
        check_frame(2'b00);

        // binary, with mode/threshold/start disturbed mid-frame
        run_frame(2'b01, 8'd100, 1'b1, 1'b1);
        check_frame(2'b01);

        // inverted binary; next frame starts the cycle after ctrl_done
        run_frame(2'b10, 8'd100, 1'b0, 1'b0);
        check_frame(2'b10);
        step();
        run_frame(2'b11, 8'd100, 1'b0, 1'b0);
        repeat (2) step();
        check_frame(2'b11);

        // reset during row 1 of a frame
        clear_logs();
        mode = 2'b00; threshold = 8'd100; start = 1'b1;
        step();
        start = 1'b0;
        i = 0;
        while (!(rd_en0 && addr0 >= 19'd4) && i < 100) begin
            step();
            i++;
        end
        check("reached_row1", 64'(addr0 >= 19'd4), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_vsync", 64'(vs0), 64'd0);
        check("midrst_hsync", 64'(hs0), 64'd0);
        check("midrst_data", 64'(data0), 64'd0);
        check("midrst_rd_en", 64'(rd_en0), 64'd0);
        check("midrst_addr", 64'(addr0), 64'd0);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_busy1", 64'(busy1), 64'd0);
        clear_logs();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (40) step();
        check("midrst_no_done", 64'(done_cnt0), 64'd0);
        check("midrst_idle", 64'(busy0), 64'd0);
        check("midrst_no_reads", 64'(rd_a0.size()), 64'd0);

        // full frame after recovery
        run_frame(2'b00, 8'd100, 1'b0, 1'b0);
        repeat (2) step();
        check_frame(2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
